// File: rtl/neuron_array_if.sv
// Stream bundle for neuron_array: broadcast activation/weight/bias input beats on one
// valid/ready pair and per-lane result vectors on the other.
interface neuron_array_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DATA_W    = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             data_in;
  logic [NUM_LANES*DATA_W-1:0]   weight_in;
  logic [NUM_LANES*DATA_W-1:0]   bias_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_LANES*DATA_W-1:0]   data_out;
  logic [NUM_LANES-1:0]          sat_flag;

  modport master (
    output in_valid, data_in, weight_in, bias_in, out_ready,
    input  in_ready, out_valid, data_out, sat_flag
  );

  modport slave (
    input  in_valid, data_in, weight_in, bias_in, out_ready,
    output in_ready, out_valid, data_out, sat_flag
  );
endinterface

// File: rtl/neuron_array.sv
// Multi-lane fully-connected neuron stage: NUM_INPUTS-beat MAC per lane, then bias, round,
// selectable activation and saturation into a back-pressurable output register.
module neuron_array #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAC_BITS  = 15,
  parameter int unsigned NUM_INPUTS = 784,
  parameter int unsigned ACC_W      = 48
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic [1:0]          i_act_mode,
  neuron_array_if.slave       bus
);
  localparam int unsigned CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_INPUTS - 1);
  localparam logic [ACC_W-1:0] RoundHalf = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] MaxVal =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinVal =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [CNT_W-1:0]              r_cnt;
  logic [1:0]                    r_mode;
  logic                          r_valid;
  logic [NUM_LANES*DATA_W-1:0]   r_data;
  logic [NUM_LANES-1:0]          r_sat;

  logic                          w_last;
  logic                          w_in_ready;
  logic                          w_accept;
  logic [1:0]                    w_mode;
  logic [NUM_LANES*DATA_W-1:0]   w_res;
  logic [NUM_LANES-1:0]          w_sat;
  logic signed [DATA_W-1:0]      w_din;

  assign w_last     = (r_cnt == LastCnt);
  assign w_in_ready = !i_flush && !(w_last && r_valid && !bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  // The first beat's mode applies to its own vector, including the single-beat case.
  assign w_mode     = (r_cnt == '0) ? i_act_mode : r_mode;
  assign w_din      = $signed(bus.data_in);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic signed [DATA_W-1:0]   w_wgt;
    logic signed [DATA_W-1:0]   w_bias;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_x;
    logic signed [ACC_W-1:0]    w_bias_x;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_r;
    logic signed [ACC_W-1:0]    w_a;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_wgt    = $signed(bus.weight_in[k*DATA_W +: DATA_W]);
    assign w_bias   = $signed(bus.bias_in[k*DATA_W +: DATA_W]);
    assign w_prod   = w_din * w_wgt;
    assign w_prod_x = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_bias_x = {{(ACC_W-DATA_W-FRAC_BITS){w_bias[DATA_W-1]}}, w_bias,
                       {FRAC_BITS{1'b0}}};
    assign w_sum    = r_acc + w_prod_x + w_bias_x + RoundHalf;
    assign w_r      = w_sum >>> FRAC_BITS;

    always_comb begin
      w_a = w_r;
      case (w_mode)
        2'd1:    w_a = w_r[ACC_W-1] ? '0 : w_r;
        2'd2:    w_a = w_r[ACC_W-1] ? (w_r >>> 3) : w_r;
        default: w_a = w_r;
      endcase
    end

    assign w_sat[k] = (w_a > MaxVal) || (w_a < MinVal);
    assign w_res[k*DATA_W +: DATA_W] = (w_a > MaxVal) ? MaxVal[DATA_W-1:0] :
                                       (w_a < MinVal) ? MinVal[DATA_W-1:0] :
                                       w_a[DATA_W-1:0];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_acc <= '0;
      end else if (i_flush) begin
        r_acc <= '0;
      end else if (w_accept) begin
        r_acc <= w_last ? '0 : (r_acc + w_prod_x);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_mode  <= 2'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sat   <= '0;
    end else begin
      if (i_flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
        if (r_cnt == '0) r_mode <= i_act_mode;
      end
      // A new result loading on the accept edge keeps out_valid high.
      if (w_accept && w_last) begin
        r_valid <= 1'b1;
        r_data  <= w_res;
        r_sat   <= w_sat;
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.data_out  = r_data;
  assign bus.sat_flag  = r_sat;
endmodule

// File: tb/tb_neuron_array.sv
// Directed self-checking bench for neuron_array with 2 lanes and 4-beat vectors.
module tb_neuron_array;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] act_mode = 2'd0;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  neuron_array_if #(.NUM_LANES(2), .DATA_W(16)) bus ();

  neuron_array #(
    .NUM_LANES(2), .DATA_W(16), .FRAC_BITS(15), .NUM_INPUTS(4), .ACC_W(48)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_flush    (flush),
    .i_act_mode (act_mode),
    .bus        (bus)
  );

  task automatic drive(input logic [15:0] d, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] b0, input logic [15:0] b1, input logic [1:0] m);
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    bus.weight_in = {w1, w0};
    bus.bias_in   = {b1, b0};
    act_mode      = m;
  endtask

  task automatic beat(input logic [15:0] d, input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] b0, input logic [15:0] b1, input logic [1:0] m);
    drive(d, w0, w1, b0, b1, m);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // 0.5 * (+0.5 / -0.5) accumulated four times; m0 on beat 1, mr on beats 2-4.
  task automatic sat_vector(input logic [1:0] m0, input logic [1:0] mr);
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, m0);
    for (int i = 0; i < 3; i++) beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, mr);
  endtask

  task automatic bias_vector();
    beat(16'h0001, 16'h4000, 16'h0000, 16'h1111, 16'h2222, 2'd0);
    beat(16'h0000, 16'h4000, 16'h0000, 16'h1111, 16'h2222, 2'd0);
    beat(16'h0000, 16'h4000, 16'h0000, 16'h1111, 16'h2222, 2'd0);
    beat(16'h0000, 16'h4000, 16'h0000, 16'h2000, 16'h0000, 2'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_cycle();
    idle_cycle();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== 32'h0 || bus.sat_flag !== 2'b00)
      $display("FAIL reset_outputs: valid=%b data=%h sat=%b, want 0/00000000/00",
               bus.out_valid, bus.data_out, bus.sat_flag);
    else n_pass++;
    rst_n = 1'b1;
    idle_cycle();
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_saturation();
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd0);
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd0);
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd0);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL sat_early_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 32'h8000_7FFF || bus.sat_flag !== 2'b01)
      $display("FAIL sat_result: valid=%b data=%h sat=%b, want 1/80007fff/01",
               bus.out_valid, bus.data_out, bus.sat_flag);
    else n_pass++;
    idle_cycle();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL sat_valid_drop: got %b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_activation();
    sat_vector(2'd1, 2'd1);
    n_checks++;
    if (bus.data_out !== 32'h0000_7FFF || bus.sat_flag !== 2'b01)
      $display("FAIL act_relu: data=%h sat=%b, want 00007fff/01", bus.data_out, bus.sat_flag);
    else n_pass++;
    sat_vector(2'd2, 2'd0);
    n_checks++;
    if (bus.data_out !== 32'hF000_7FFF || bus.sat_flag !== 2'b01)
      $display("FAIL act_leaky_latched: data=%h sat=%b, want f0007fff/01",
               bus.data_out, bus.sat_flag);
    else n_pass++;
    sat_vector(2'd0, 2'd1);
    n_checks++;
    if (bus.data_out !== 32'h8000_7FFF)
      $display("FAIL act_linear_latched: data=%h want 80007fff", bus.data_out);
    else n_pass++;
    sat_vector(2'd3, 2'd2);
    n_checks++;
    if (bus.data_out !== 32'h8000_7FFF)
      $display("FAIL act_mode3_linear: data=%h want 80007fff", bus.data_out);
    else n_pass++;
    idle_cycle();
  endtask

  task automatic test_bias_round();
    bias_vector();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 32'h0000_2001 || bus.sat_flag !== 2'b00)
      $display("FAIL bias_round: valid=%b data=%h sat=%b, want 1/00002001/00",
               bus.out_valid, bus.data_out, bus.sat_flag);
    else n_pass++;
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    sat_vector(2'd0, 2'd0);
    bus.out_ready = 1'b0;
    beat(16'h0001, 16'h4000, 16'h0000, 16'h1111, 16'h2222, 2'd0);
    beat(16'h0000, 16'h4000, 16'h0000, 16'h1111, 16'h2222, 2'd0);
    drive(16'h0000, 16'h4000, 16'h0000, 16'h1111, 16'h2222, 2'd0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_beat3_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    drive(16'h0000, 16'h4000, 16'h0000, 16'h2000, 16'h0000, 2'd0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_final_stall: got %b want 0", bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 32'h8000_7FFF || bus.sat_flag !== 2'b01)
      $display("FAIL bp_hold_a: valid=%b data=%h sat=%b, want 1/80007fff/01",
               bus.out_valid, bus.data_out, bus.sat_flag);
    else n_pass++;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 32'h0000_2001 || bus.sat_flag !== 2'b00)
      $display("FAIL bp_load_b: valid=%b data=%h sat=%b, want 1/00002001/00",
               bus.out_valid, bus.data_out, bus.sat_flag);
    else n_pass++;
    idle_cycle();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_b_drained: got %b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd1);
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd1);
    drive(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd1);
    flush = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    bias_vector();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 32'h0000_2001)
      $display("FAIL flush_fresh: valid=%b data=%h, want 1/00002001",
               bus.out_valid, bus.data_out);
    else n_pass++;
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bias_vector();
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd0);
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd0);
    rst_n = 1'b0;
    idle_cycle();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== 32'h0 || bus.sat_flag !== 2'b00)
      $display("FAIL midreset_outputs: valid=%b data=%h sat=%b, want 0/00000000/00",
               bus.out_valid, bus.data_out, bus.sat_flag);
    else n_pass++;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd2);
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd2);
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd2);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL midreset_cnt: valid=%b want 0", bus.out_valid);
    else n_pass++;
    beat(16'h4000, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'd2);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 32'hF000_7FFF || bus.sat_flag !== 2'b01)
      $display("FAIL midreset_result: valid=%b data=%h sat=%b, want 1/f0007fff/01",
               bus.out_valid, bus.data_out, bus.sat_flag);
    else n_pass++;
    idle_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.weight_in = '0;
    bus.bias_in   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_saturation();
    test_activation();
    test_bias_round();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
